// File: rtl/logiclab_pkg.sv
// Shared definitions for the flip-flop pattern checker slice.
//   state_t      : checker FSM states (IDLE, RUN, DONE)
//   MODE_*       : pattern select encodings
//   LFSR_TAPS    : feedback mask for x^8+x^6+x^5+x^4+1, right-shifting form
//   lfsr_step()  : one Fibonacci advance, feedback enters at bit 7
package logiclab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ALT   = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ZEROS = 2'b10;
    localparam logic [1:0] MODE_LFSR  = 2'b11;

    // Taps 8,6,5,4 map to bits 0,2,3,4 when the register shifts right.
    localparam logic [7:0] LFSR_TAPS = 8'b0001_1101;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {^(cur & LFSR_TAPS), cur[7:1]};
    endfunction

endpackage

// File: rtl/dff_pattern_checker_if.sv
// Control/status bus of the pattern checker.
//   start, mode, length          : run request (master -> slave)
//   busy, done, pass,
//   err_count, first_err_idx     : run status (slave -> master)
interface dff_pattern_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] length;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err_idx;

    modport master (
        output start, mode, length,
        input  busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        input  start, mode, length,
        output busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/dff_pattern_gen.sv
// Pattern bit generator.
//   mode     : pattern select
//   odd      : parity of the bit index being produced (1 = odd index)
//   lfsr_bit : bit 0 of the LFSR state belonging to that index
//   bit_out  : pattern bit
module dff_pattern_gen
    import logiclab_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       odd,
    input  logic       lfsr_bit,
    output logic       bit_out
);

    always_comb begin
        bit_out = 1'b0;
        case (mode)
            MODE_ALT:   bit_out = ~odd;
            MODE_ONES:  bit_out = 1'b1;
            MODE_ZEROS: bit_out = 1'b0;
            MODE_LFSR:  bit_out = lfsr_bit;
            default:    bit_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/negedge_d_ff.sv
// Falling-edge D flip-flop used as the device under test of the checker.
//   D, CLK : data and clock
//   Q, Q_n : true and complement outputs
module negedge_d_ff (
    input  logic D,
    input  logic CLK,
    output logic Q,
    output logic Q_n
);

    logic q_r;

    always_ff @(negedge CLK) begin
        q_r <= D;
    end

    assign Q   = q_r;
    assign Q_n = ~q_r;

endmodule

// File: rtl/dff_pattern_checker.sv
// Drives a bit pattern into a falling-edge flip-flop and scores its outputs.
//   CLK, RST_n : clock, asynchronous active-low reset
//   bus        : start/mode/length request, busy/done/pass/err_count/first_err_idx status
//   D          : stimulus bit to the flip-flop
//   Q, Q_n     : flip-flop outputs returned for checking
module dff_pattern_checker
    import logiclab_pkg::*;
#(
    parameter int         CNT_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    dff_pattern_checker_if.slave      bus,
    output logic                      D,
    input  logic                      Q,
    input  logic                      Q_n
);

    state_t           state;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] idx;
    logic [7:0]       lfsr;
    logic [CNT_W-1:0] err_r;
    logic [CNT_W-1:0] first_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             d_r;

    logic             accept;
    logic             bit_fail;
    logic             last_bit;
    logic [7:0]       lfsr_adv;
    logic [CNT_W-1:0] err_next;
    logic [CNT_W-1:0] first_next;
    logic [1:0]       gen_mode;
    logic             gen_odd;
    logic             gen_lfsr_bit;
    logic             gen_bit;

    always_comb begin
        accept   = bus.start && (bus.length != '0) && (state != ST_RUN);
        // Expected value is the D driven one edge earlier, still held in d_r.
        bit_fail = (Q != d_r) || (Q_n == Q);
        last_bit = (idx == len_r - CNT_W'(1));
        lfsr_adv = lfsr_step(lfsr);

        err_next   = err_r;
        first_next = first_r;
        if (bit_fail) begin
            if (err_r != '1)
                err_next = err_r + CNT_W'(1);
            if (first_r == '1)
                first_next = idx;
        end

        // One generator serves both bit 0 at acceptance (live inputs, seed)
        // and bit idx+1 during the run (latched mode, advanced LFSR).
        if (state == ST_RUN) begin
            gen_mode     = mode_r;
            gen_odd      = ~idx[0];
            gen_lfsr_bit = lfsr_adv[0];
        end else begin
            gen_mode     = bus.mode;
            gen_odd      = 1'b0;
            gen_lfsr_bit = LFSR_SEED[0];
        end
    end

    dff_pattern_gen u_gen (
        .mode     (gen_mode),
        .odd      (gen_odd),
        .lfsr_bit (gen_lfsr_bit),
        .bit_out  (gen_bit)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= ST_IDLE;
            mode_r  <= MODE_ALT;
            len_r   <= '0;
            idx     <= '0;
            lfsr    <= LFSR_SEED;
            err_r   <= '0;
            first_r <= '1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            d_r     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state   <= ST_RUN;
                        mode_r  <= bus.mode;
                        len_r   <= bus.length;
                        idx     <= '0;
                        lfsr    <= LFSR_SEED;
                        err_r   <= '0;
                        first_r <= '1;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        d_r     <= gen_bit;
                    end
                end
                ST_RUN: begin
                    err_r   <= err_next;
                    first_r <= first_next;
                    if (last_bit) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (err_next == '0);
                        d_r    <= 1'b0;
                    end else begin
                        idx  <= idx + CNT_W'(1);
                        lfsr <= lfsr_adv;
                        d_r  <= gen_bit;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    d_r    <= 1'b0;
                end
            endcase
        end
    end

    assign D                 = d_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.pass          = pass_r;
    assign bus.err_count     = err_r;
    assign bus.first_err_idx = first_r;

endmodule

// File: doc/dff_pattern_checker.md
DFF_PATTERN_CHECKER -- requirements
Module: dff_pattern_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of length, index and error counters.
REQ-002 Parameter LFSR_SEED, default 8'hA5: LFSR load value at each accepted start.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a test run; sampled on rising CLK.
REQ-006 mode  input  2  pattern select: 00 alternating 1,0,1,..; 01 all ones; 10 all zeros; 11 LFSR.
REQ-007 length  input  CNT_W  number of pattern bits to drive and check; 0 means no run.
REQ-008 D  output  1  stimulus bit to the negedge flip-flop under test.
REQ-009 Q  input  1  flip-flop true output.
REQ-010 Q_n  input  1  flip-flop complement output.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run completion until next accepted start or reset.
REQ-013 pass  output  1  high in DONE iff err_count == 0; low otherwise.
REQ-014 err_count  output  CNT_W  number of failing bit indices, saturating at all-ones.
REQ-015 first_err_idx  output  CNT_W  index of first failing bit; all-ones if none.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-017 In IDLE or DONE, start=1 with length!=0 is accepted: latch mode and length, clear err_count, set first_err_idx all-ones, load LFSR with LFSR_SEED, drive D = pattern bit 0, idx = 0, go RUN.
REQ-018 start with length==0 is ignored; start while in RUN is ignored; mode/length changes during RUN have no effect.
REQ-019 Each rising edge in RUN checks bit idx: expected = D value driven at the previous edge (latency one cycle, the DUT having captured it on the intervening falling edge).
REQ-020 Bit idx fails if Q != expected or Q_n != ~Q; one failing index counts once.
REQ-021 On failure: err_count increments unless already all-ones; first_err_idx takes idx if still all-ones.
REQ-022 In RUN, if idx == length-1, go DONE after the check; otherwise drive D = pattern bit idx+1 and increment idx.
REQ-023 A run occupies exactly 1 + length rising edges from acceptance to DONE entry.
REQ-024 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, pattern bit = lfsr[0], advanced once per driven bit after bit 0.
REQ-025 D = 0 in IDLE and DONE; busy = (state == RUN); done = (state == DONE).
REQ-026 Restart from DONE re-enters RUN directly; done falls and busy rises on the accepting edge.

Reset
REQ-027 RST_n low asynchronously forces: state IDLE, D=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones, idx=0, LFSR=LFSR_SEED.
REQ-028 Reset asserted mid-RUN aborts the run with no partial result retained; first start after release behaves as from power-up.

Structure
REQ-029 Shared package logiclab_pkg holds state encoding, mode constants and LFSR tap mask.
REQ-030 One sub-module, dff_pattern_gen, produces the pattern bit from mode, idx parity and LFSR state; FSM and scoreboard stay in dff_pattern_checker.

Verification
REQ-031 Bench instantiates the existing negedge_d_ff with D, CLK, Q, Q_n wired to the checker; 100 ns clock period.
REQ-032 mode=00, length=10 -> D sequence 1,0,1,0,1,0,1,0,1,0; done after 11 edges; err_count=0, pass=1, first_err_idx=8'hFF.
REQ-033 mode=11, length=16 -> D equals LFSR sequence from seed 8'hA5; pass=1.
REQ-034 mode=01, length=8, bench forces Q=0 at bit indices 3 and 5 -> err_count=2, first_err_idx=3, pass=0.
REQ-035 mode=00, length=200, RST_n pulsed low at bit 50 -> all outputs reset values immediately; new start with length=4 completes with pass=1.
REQ-036 length=0 start -> stays IDLE; start during RUN ignored; err_count saturates at 8'hFF when Q_n tied to Q for length=255 run.
